// File: rtl/inst_queue_pkg.sv
// Shared types, defaults and helpers for the dual-issue instruction queue.

// Project-wide defaults. A shared define file compiled earlier takes precedence.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef IQ_DEPTH
`define IQ_DEPTH 8
`endif

package inst_queue_pkg;

  localparam int unsigned IqDepth     = `IQ_DEPTH;
  localparam int unsigned IqAddrWidth = `ADDR_WIDTH;
  localparam int unsigned IqInstWidth = `INST_WIDTH;

  // Number of slots decode consumes this cycle, given current occupancy.
  function automatic int unsigned iq_pop_num(int unsigned cnt, logic single);
    int unsigned want;
    want = single ? 1 : 2;
    return (cnt < want) ? cnt : want;
  endfunction

  // Number of lanes fetch writes this cycle; lane 1 only counts alongside lane 0.
  function automatic int unsigned iq_push_num(logic ready, logic [1:0] valid);
    if (!ready || !valid[0]) begin
      return 0;
    end
    return valid[1] ? 2 : 1;
  endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// 2-write / 2-read register array with asynchronous read. No reset on contents.

module inst_queue_ram
  import inst_queue_pkg::*;
#(
  parameter int unsigned Depth = IqDepth,
  parameter int unsigned Width = IqAddrWidth + IqInstWidth,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we0_i,
  input  logic [AddrW-1:0] waddr0_i,
  input  logic [Width-1:0] wdata0_i,
  input  logic             we1_i,
  input  logic [AddrW-1:0] waddr1_i,
  input  logic [Width-1:0] wdata1_i,
  input  logic [AddrW-1:0] raddr0_i,
  output logic [Width-1:0] rdata0_o,
  input  logic [AddrW-1:0] raddr1_i,
  output logic [Width-1:0] rdata1_o
);

  logic [Width-1:0] mem_q [Depth];

  // Write both lanes; the two write addresses are always consecutive and distinct.
  always_ff @(posedge clk_i) begin
    if (we0_i) begin
      mem_q[waddr0_i] <= wdata0_i;
    end
    if (we1_i) begin
      mem_q[waddr1_i] <= wdata1_i;
    end
  end

  // Show-ahead read ports.
  always_comb begin
    rdata0_o = mem_q[raddr0_i];
    rdata1_o = mem_q[raddr1_i];
  end

endmodule

// File: rtl/inst_queue.sv
// Dual-issue instruction queue between fetch and the two decode slots.

module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH      = IqDepth,
  parameter int unsigned ADDR_WIDTH = IqAddrWidth,
  parameter int unsigned INST_WIDTH = IqInstWidth,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            push_valid,
  input  logic [ADDR_WIDTH-1:0] push_pc0,
  input  logic [ADDR_WIDTH-1:0] push_pc1,
  input  logic [INST_WIDTH-1:0] push_inst0,
  input  logic [INST_WIDTH-1:0] push_inst1,
  output logic                  push_ready,
  input  logic                  ctrl_stall,
  input  logic                  ctrl_flush,
  input  logic                  issue_single,
  output logic                  id_valid0,
  output logic                  id_valid1,
  output logic [ADDR_WIDTH-1:0] id_pc0,
  output logic [ADDR_WIDTH-1:0] id_pc1,
  output logic [INST_WIDTH-1:0] id_inst0,
  output logic [INST_WIDTH-1:0] id_inst1,
  output logic [CntW-1:0]       q_count,
  output logic                  q_empty,
  output logic                  q_full
);

  localparam int unsigned EntW = ADDR_WIDTH + INST_WIDTH;

  logic [PtrW-1:0] wp_q, wp_d;
  logic [PtrW-1:0] rp_q, rp_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] np, nd;
  logic [EntW-1:0] rdata0, rdata1;

  // Ready depends only on registered occupancy so a same-cycle pop never raises it.
  always_comb begin
    push_ready = (cnt_q <= CntW'(DEPTH - 2));
  end

  // Push/pop counts and next-state pointers; flush wins over everything else.
  always_comb begin
    np = CntW'(iq_push_num(push_ready, push_valid));
    nd = '0;
    if (!ctrl_stall && !ctrl_flush) begin
      nd = CntW'(iq_pop_num(32'(cnt_q), issue_single));
    end
    wp_d  = wp_q + PtrW'(np);
    rp_d  = rp_q + PtrW'(nd);
    cnt_d = cnt_q + np - nd;
    if (ctrl_flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end
  end

  // Pointer and occupancy state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  inst_queue_ram #(
    .Depth (DEPTH),
    .Width (EntW)
  ) u_ram (
    .clk_i    (clk),
    .we0_i    (!ctrl_flush && (np != '0)),
    .waddr0_i (wp_q),
    .wdata0_i ({push_pc0, push_inst0}),
    .we1_i    (!ctrl_flush && (np == CntW'(2))),
    .waddr1_i (wp_q + PtrW'(1)),
    .wdata1_i ({push_pc1, push_inst1}),
    .raddr0_i (rp_q),
    .rdata0_o (rdata0),
    .raddr1_i (rp_q + PtrW'(1)),
    .rdata1_o (rdata1)
  );

  // Slot outputs, zeroed when the slot is not valid; status flags.
  always_comb begin
    id_valid0 = (cnt_q >= CntW'(1));
    id_valid1 = (cnt_q >= CntW'(2));
    id_pc0    = id_valid0 ? rdata0[EntW-1:INST_WIDTH] : '0;
    id_inst0  = id_valid0 ? rdata0[INST_WIDTH-1:0]    : '0;
    id_pc1    = id_valid1 ? rdata1[EntW-1:INST_WIDTH] : '0;
    id_inst1  = id_valid1 ? rdata1[INST_WIDTH-1:0]    : '0;
    q_count   = cnt_q;
    q_empty   = (cnt_q == '0);
    q_full    = (cnt_q == CntW'(DEPTH));
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue (DEPTH=8).

module tb_inst_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 32;
  localparam int unsigned IW    = 32;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    push_valid;
  logic [AW-1:0] push_pc0, push_pc1;
  logic [IW-1:0] push_inst0, push_inst1;
  logic          push_ready;
  logic          ctrl_stall, ctrl_flush, issue_single;
  logic          id_valid0, id_valid1;
  logic [AW-1:0] id_pc0, id_pc1;
  logic [IW-1:0] id_inst0, id_inst1;
  logic [CW-1:0] q_count;
  logic          q_empty, q_full;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_queue #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .INST_WIDTH (IW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid   (push_valid),
    .push_pc0     (push_pc0),
    .push_pc1     (push_pc1),
    .push_inst0   (push_inst0),
    .push_inst1   (push_inst1),
    .push_ready   (push_ready),
    .ctrl_stall   (ctrl_stall),
    .ctrl_flush   (ctrl_flush),
    .issue_single (issue_single),
    .id_valid0    (id_valid0),
    .id_valid1    (id_valid1),
    .id_pc0       (id_pc0),
    .id_pc1       (id_pc1),
    .id_inst0     (id_inst0),
    .id_inst1     (id_inst1),
    .q_count      (q_count),
    .q_empty      (q_empty),
    .q_full       (q_full)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [1:0] v, input logic [31:0] pc);
    push_valid = v;
    push_pc0   = pc;
    push_pc1   = pc + 32'd4;
    push_inst0 = inst_of(pc);
    push_inst1 = inst_of(pc + 32'd4);
  endtask

  task automatic flush_cycle();
    ctrl_flush = 1'b1;
    tick();
    ctrl_flush = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_v0"},    64'(id_valid0),  64'd0);
    check({tag, "_v1"},    64'(id_valid1),  64'd0);
    check({tag, "_pc0"},   64'(id_pc0),     64'd0);
    check({tag, "_pc1"},   64'(id_pc1),     64'd0);
    check({tag, "_inst0"}, 64'(id_inst0),   64'd0);
    check({tag, "_inst1"}, 64'(id_inst1),   64'd0);
    check({tag, "_cnt"},   64'(q_count),    64'd0);
    check({tag, "_empty"}, 64'(q_empty),    64'd1);
    check({tag, "_full"},  64'(q_full),     64'd0);
    check({tag, "_rdy"},   64'(push_ready), 64'd1);
  endtask

  initial begin
    int mc, np, nd, next_push, next_pop, cyc, lanes;
    logic [31:0] base;

    rst_n        = 1'b0;
    ctrl_stall   = 1'b0;
    ctrl_flush   = 1'b0;
    issue_single = 1'b0;
    set_push(2'b00, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    check_reset_state("reset");

    // Dual push into empty queue becomes visible next cycle.
    ctrl_stall = 1'b1;
    set_push(2'b11, 32'h100);
    tick();
    set_push(2'b00, 32'h0);
    check("dual_v0",    64'(id_valid0), 64'd1);
    check("dual_v1",    64'(id_valid1), 64'd1);
    check("dual_pc0",   64'(id_pc0),    64'h100);
    check("dual_pc1",   64'(id_pc1),    64'h104);
    check("dual_inst1", 64'(id_inst1),  64'(32'hA5A5_0104));
    check("dual_cnt",   64'(q_count),   64'd2);

    // Single issue shifts slot 1 into slot 0.
    flush_cycle();
    set_push(2'b11, 32'h200);
    tick();
    set_push(2'b01, 32'h208);
    tick();
    set_push(2'b00, 32'h0);
    check("single_pre_cnt", 64'(q_count), 64'd3);
    ctrl_stall   = 1'b0;
    issue_single = 1'b1;
    tick();
    ctrl_stall   = 1'b1;
    issue_single = 1'b0;
    check("single_pc0", 64'(id_pc0),  64'h204);
    check("single_pc1", 64'(id_pc1),  64'h208);
    check("single_cnt", 64'(q_count), 64'd2);

    // Fill to DEPTH-1; ready drops with one free entry.
    flush_cycle();
    set_push(2'b11, 32'h300);
    tick();
    set_push(2'b11, 32'h308);
    tick();
    set_push(2'b11, 32'h310);
    tick();
    check("two_free_rdy", 64'(push_ready), 64'd1);
    set_push(2'b01, 32'h318);
    tick();
    check("one_free_cnt", 64'(q_count),    64'd7);
    check("one_free_rdy", 64'(push_ready), 64'd0);
    set_push(2'b11, 32'h320);
    tick();
    check("drop_dual_cnt", 64'(q_count), 64'd7);
    set_push(2'b01, 32'h320);
    tick();
    set_push(2'b00, 32'h0);
    check("drop_single_cnt", 64'(q_count), 64'd7);
    check("drop_pc0",        64'(id_pc0),  64'h300);
    check("drop_full",       64'(q_full),  64'd0);

    // Full queue, pop with a push attempt: push dropped, ready back next cycle.
    flush_cycle();
    for (int i = 0; i < 4; i++) begin
      set_push(2'b11, 32'h300 + 32'(8 * i));
      tick();
    end
    check("full_flag", 64'(q_full),     64'd1);
    check("full_rdy",  64'(push_ready), 64'd0);
    set_push(2'b11, 32'h400);
    ctrl_stall = 1'b0;
    tick();
    ctrl_stall = 1'b1;
    set_push(2'b00, 32'h0);
    check("full_pop_cnt", 64'(q_count),    64'd6);
    check("full_pop_rdy", 64'(push_ready), 64'd1);
    check("full_pop_pc0", 64'(id_pc0),     64'h308);

    // Lane 1 without lane 0 is ignored.
    flush_cycle();
    set_push(2'b10, 32'h500);
    tick();
    set_push(2'b00, 32'h0);
    check("lane1_only_cnt", 64'(q_count),   64'd0);
    check("lane1_only_v0",  64'(id_valid0), 64'd0);

    // Stall holds slots while pushes continue.
    check("stall_cnt0", 64'(q_count), 64'd0);
    for (int i = 0; i < 3; i++) begin
      set_push(2'b11, 32'h600 + 32'(8 * i));
      tick();
      check("stall_cnt", 64'(q_count), 64'(2 * (i + 1)));
      check("stall_pc0", 64'(id_pc0),  64'h600);
      check("stall_pc1", 64'(id_pc1),  64'h604);
    end
    set_push(2'b00, 32'h0);

    // Flush with cnt=5 and a same-cycle push discards everything.
    flush_cycle();
    set_push(2'b11, 32'h700);
    tick();
    set_push(2'b11, 32'h708);
    tick();
    set_push(2'b01, 32'h710);
    tick();
    check("pre_flush_cnt", 64'(q_count), 64'd5);
    set_push(2'b11, 32'h780);
    ctrl_flush = 1'b1;
    tick();
    ctrl_flush = 1'b0;
    check("flush_cnt",   64'(q_count),   64'd0);
    check("flush_v0",    64'(id_valid0), 64'd0);
    check("flush_empty", 64'(q_empty),   64'd1);
    set_push(2'b11, 32'h800);
    tick();
    set_push(2'b00, 32'h0);
    check("post_flush_pc0", 64'(id_pc0),  64'h800);
    check("post_flush_cnt", 64'(q_count), 64'd2);

    // Wrap-around stream of 20 sequential PCs with random pop width and stalls.
    flush_cycle();
    base      = 32'h1000;
    mc        = 0;
    next_push = 0;
    next_pop  = 0;
    cyc       = 0;
    while (next_pop < 20 && cyc < 300) begin
      check("wrap_cnt", 64'(q_count),    64'(mc));
      check("wrap_rdy", 64'(push_ready), 64'(mc <= 6));
      check("wrap_v0",  64'(id_valid0),  64'(mc >= 1));
      check("wrap_v1",  64'(id_valid1),  64'(mc >= 2));
      if (mc >= 1) begin
        check("wrap_pc0",   64'(id_pc0),   64'(base + 32'(4 * next_pop)));
        check("wrap_inst0", 64'(id_inst0), 64'(inst_of(base + 32'(4 * next_pop))));
      end
      if (mc >= 2) begin
        check("wrap_pc1", 64'(id_pc1), 64'(base + 32'(4 * (next_pop + 1))));
      end
      np = 0;
      if (next_push < 20) begin
        lanes = (next_push == 19) ? 1 : int'($urandom_range(1, 2));
        set_push((lanes == 2) ? 2'b11 : 2'b01, base + 32'(4 * next_push));
        if (mc <= 6) begin
          np = lanes;
        end
      end else begin
        set_push(2'b00, 32'h0);
      end
      ctrl_stall   = ($urandom_range(0, 3) == 0);
      issue_single = 1'($urandom_range(0, 1));
      if (ctrl_stall) begin
        nd = 0;
      end else if (issue_single) begin
        nd = (mc >= 1) ? 1 : 0;
      end else begin
        nd = (mc >= 2) ? 2 : mc;
      end
      tick();
      mc        = mc + np - nd;
      next_push = next_push + np;
      next_pop  = next_pop + nd;
      cyc++;
    end
    check("wrap_popped", 64'(next_pop), 64'd20);
    set_push(2'b00, 32'h0);
    issue_single = 1'b0;

    // Reset mid-stream behaves like a flush.
    ctrl_stall = 1'b1;
    set_push(2'b11, 32'h900);
    tick();
    rst_n = 1'b0;
    set_push(2'b11, 32'h910);
    tick();
    rst_n = 1'b1;
    set_push(2'b00, 32'h0);
    check_reset_state("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
# inst_queue

Dual-issue instruction queue between the fetch stage (Icache return) and the two decode slots. It sits directly upstream of the pipeline control unit's IF/ID boundary and consumes that unit's IF stall bit, IF/ID flush bit and single-issue select. It buffers up to DEPTH fetched instructions and presents the oldest two to decode slots 0 and 1 each cycle. On a branch or exception redirect it drops everything in flight.

## Interface
- DEPTH, 8, number of entries; power of two, ≥4
- ADDR_WIDTH, 32, PC width (`ADDR_WIDTH` from the shared define file)
- INST_WIDTH, 32, instruction word width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- push_valid  in  2  lane enables; [1] is honoured only with [0]
- push_pc0, push_pc1  in  ADDR_WIDTH  PCs of lanes 0/1
- push_inst0, push_inst1  in  INST_WIDTH  instruction words of lanes 0/1
- push_ready  out  1  at least 2 free entries this cycle
- ctrl_stall  in  1  IF-stage stall from control (stall vector bit 0); blocks pop
- ctrl_flush  in  1  IF/ID flush from control (flush vector bit 0)
- issue_single  in  1  only slot 0 is consumed this cycle (issue select bit 0)
- id_valid0, id_valid1  out  1  slot 0/1 holds a valid instruction
- id_pc0, id_pc1  out  ADDR_WIDTH  slot PCs
- id_inst0, id_inst1  out  INST_WIDTH  slot instruction words
- q_count  out  $clog2(DEPTH)+1  current occupancy
- q_empty, q_full  out  1  count==0 / count==DEPTH

## Operation
- Storage: DEPTH-entry circular buffer of {pc, inst}, write pointer wp, read pointer rp, counter cnt. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push count: np = 0 if !push_ready or !push_valid[0]; else 1 + push_valid[1]. Lane 0 is written at wp, lane 1 at wp+1. wp += np.
- push_ready = (DEPTH − cnt) ≥ 2. It is computed from the registered cnt only. A same-cycle pop never raises it. A push while !push_ready is dropped; fetch holds its data until ready.
- Slot outputs are show-ahead: slot 0 = entry rp, slot 1 = entry rp+1. id_valid0 = cnt≥1 and id_valid1 = cnt≥2. pc and inst are forced to 0 when the corresponding valid is low.
- Pop count when !ctrl_stall and !ctrl_flush: nd = issue_single ? min(1,cnt) : min(2,cnt). Otherwise nd = 0. rp += nd.
- An instruction left in slot 1 under issue_single moves to slot 0 on the next cycle.
- cnt_next = cnt + np − nd.
- Flush: wp, rp and cnt are cleared to 0, and pushes in that cycle are discarded. Flush has priority over stall, push and pop.
- Reset (rst_n low at a clock edge): wp=rp=cnt=0. This gives id_valid0/1=0, all id_pc/id_inst=0, q_count=0, q_empty=1, q_full=0, and push_ready=1. Storage contents are not reset. Reset mid-operation discards all entries, the same as flush.

## Timing
- Push→visible: data pushed in cycle t appears on slot outputs in cycle t+1 (no bypass when empty).
- Pop is same-cycle: the slot outputs in cycle t are consumed at the edge ending t, and the next entries appear in t+1.
- Flush in cycle t gives id_valid0/1=0 in t+1. The first post-flush push lands in t+1 and is visible in t+2.
- Stall freezes the pointer rp. Pushes continue while push_ready is high.
- Full queue with a simultaneous pop: push_ready is 0, so no push occurs. Occupancy drops and ready is reasserted next cycle.
- Exactly 1 free entry: push_ready=0 even for a single-lane push.

## Structure
- ADDR_WIDTH and INST_WIDTH come from the shared define file. Add `IQ_DEPTH` there as the project-wide default.
- Split the storage into one sub-module, `inst_queue_ram`. It is a 2-write/2-read register array with async read, and contains no reset.
- The pointer, counter and ready logic stay in `inst_queue`.

## Test plan
- Reset then push_valid=2'b11 (pc 0x100/0x104) → next cycle id_valid0/1=1, id_pc0=0x100, id_pc1=0x104, q_count=2.
- Hold 3 entries (0x200/0x204/0x208) with issue_single=1 → next cycle id_pc0=0x204, id_pc1=0x208, q_count=2.
- Fill to DEPTH−1, then push 2'b11 → push dropped, push_ready=0, q_count unchanged at 7.
- ctrl_stall=1 for 3 cycles while pushing pairs into an empty queue → slot outputs constant and q_count 0→2→4→6.
- ctrl_flush=1 with push 2'b11 and cnt=5 in the same cycle → next cycle q_count=0, id_valid0=0, q_empty=1.
- Wrap-around: stream 20 sequential PCs through DEPTH=8 with random single/dual pop → output PC order strictly +4 with no loss or duplication.
- rst_n=0 mid-stream for 1 cycle → next cycle all outputs at their reset values.
